// File: rtl/uart_frame_tx_if.sv
// Parallel-side request bus and serial status for uart_frame_tx.
interface uart_frame_tx_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [PRESCALE_W-1:0] prescale;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, prescale,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, prescale,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start, data (MSB first), optional parity, stop.
// Define UART_TX_LSB_FIRST_EN to send data bits LSB first instead.
module uart_frame_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  uart_frame_tx_if.slave tx_if
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_LSB_FIRST_EN
  localparam logic [IDX_W-1:0] IDX_FIRST = '0;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
`else
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  bit_end;
  logic                  par_bit;
  logic [IDX_W-1:0]      idx_next;

  assign bit_end = (cnt_q == (presc_q - PRESCALE_W'(1)));
  assign par_bit = par_typ_q ? ~^data_q : ^data_q;
`ifdef UART_TX_LSB_FIRST_EN
  assign idx_next = idx_q + IDX_W'(1);
`else
  assign idx_next = idx_q - IDX_W'(1);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Line value for the next cycle is chosen at each bit boundary so tx_q is registered.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + PRESCALE_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_if.data_valid) begin
          data_d    = tx_if.p_data;
          par_en_d  = tx_if.par_en;
          par_typ_d = tx_if.par_typ;
          presc_d   = (tx_if.prescale == '0) ? PRESCALE_W'(1) : tx_if.prescale;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = S_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = IDX_FIRST;
          tx_d    = data_q[IDX_FIRST];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_next;
            tx_d  = data_q[idx_next];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_if.tx_out = tx_q;
  assign tx_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: fixed frame table, held-valid and reset sequences, random frames vs. a bit-list model.
module tb_uart_frame_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;

  typedef bit bitq_t[$];

  typedef struct {
    logic [7:0]  d;
    bit          pe;
    bit          pt;
    logic [5:0]  ps;
    logic [10:0] bits;
    int          nbits;
    int          len;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  uart_frame_tx_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();

  uart_frame_tx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .tx_if   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame as the ordered list of line bits, built from the framing rules.
  function automatic bitq_t model_frame(input logic [7:0] d, input bit pe, input bit pt);
    bitq_t q;
    int ones;
    q = {};
    q.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) begin
`ifdef UART_TX_LSB_FIRST_EN
      q.push_back(d[i]);
`else
      q.push_back(d[int'(DW) - 1 - i]);
`endif
    end
    if (pe) begin
      ones = $countones(d);
      if (pt) q.push_back((ones % 2) == 0);
      else    q.push_back((ones % 2) == 1);
    end
    q.push_back(1'b1);
    return q;
  endfunction

  task automatic idle_check(input string name);
    @(negedge clk);
    chk({name, ".idle_tx"}, 32'(bus.tx_out), 32'd1);
    chk({name, ".idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // Call just after a negedge; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input logic [5:0] ps);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.prescale   = ps;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
  endtask

  task automatic check_frame(input string name, input bitq_t bits, input int p,
                             input int exp_len, input bit scramble);
    int total;
    int busy_cnt;
    total = bits.size() * p;
    busy_cnt = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      chk({name, ".tx"}, 32'(bus.tx_out), 32'(bits[c / p]));
      if (bus.busy === 1'b1) busy_cnt++;
      if (scramble) begin
        bus.p_data     = 8'($urandom);
        bus.par_en     = 1'($urandom);
        bus.par_typ    = 1'($urandom);
        bus.prescale   = 6'($urandom);
        bus.data_valid = (c < total - 1) && ($urandom_range(0, 7) == 0);
      end
    end
    chk({name, ".busy_len"}, 32'(busy_cnt), 32'(exp_len));
  endtask

  vec_t  tbl[4];
  bitq_t q;
  int    p;

  initial begin
`ifdef UART_TX_LSB_FIRST_EN
    tbl[0] = '{8'h01, 1'b1, 1'b0, 6'd8,  11'b01000000011, 11, 88};
    tbl[1] = '{8'h55, 1'b1, 1'b0, 6'd8,  11'b01010101001, 11, 88};
    tbl[2] = '{8'h0F, 1'b0, 1'b0, 6'd0,  11'b00111100001, 10, 10};
    tbl[3] = '{8'hA0, 1'b1, 1'b1, 6'd16, 11'b00000010111, 11, 176};
`else
    tbl[0] = '{8'h55, 1'b1, 1'b0, 6'd8,  11'b00101010101, 11, 88};
    tbl[1] = '{8'hA0, 1'b1, 1'b1, 6'd16, 11'b01010000011, 11, 176};
    tbl[2] = '{8'h0F, 1'b0, 1'b0, 6'd0,  11'b00000011111, 10, 10};
    tbl[3] = '{8'h80, 1'b1, 1'b0, 6'd3,  11'b01000000011, 11, 33};
`endif

    bus.p_data = '0;
    bus.data_valid = 1'b0;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    bus.prescale = '0;

    @(negedge clk);
    chk("reset.tx", 32'(bus.tx_out), 32'd1);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) idle_check("post_reset");

    for (int v = 0; v < 4; v++) begin
      q = {};
      for (int k = 0; k < tbl[v].nbits; k++) q.push_back(tbl[v].bits[tbl[v].nbits - 1 - k]);
      p = (tbl[v].ps == 0) ? 1 : int'(tbl[v].ps);
      send(tbl[v].d, tbl[v].pe, tbl[v].pt, tbl[v].ps);
      check_frame($sformatf("tbl%0d", v), q, p, tbl[v].len, 1'b1);
      idle_check($sformatf("tbl%0d", v));
    end

    // Held request: two frames separated by exactly one idle cycle.
    bus.p_data = 8'h33;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    bus.prescale = 6'd8;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1 bus.p_data = 8'h44;
    check_frame("held_33", model_frame(8'h33, 1'b0, 1'b0), 8, 80, 1'b0);
    idle_check("held_gap");
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    check_frame("held_44", model_frame(8'h44, 1'b0, 1'b0), 8, 80, 1'b0);
    idle_check("held_end");
    idle_check("held_end2");

    for (int r = 0; r < 20; r++) begin
      logic [7:0] d;
      bit pe, pt;
      logic [5:0] ps;
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      ps = 6'($urandom_range(0, 5));
      p  = (ps == 0) ? 1 : int'(ps);
      send(d, pe, pt, ps);
      check_frame($sformatf("rnd%0d", r), model_frame(d, pe, pt), p,
                  (2 + int'(DW) + int'(pe)) * p, 1'b1);
      idle_check($sformatf("rnd%0d", r));
    end

    // Asynchronous reset mid-frame, then release together with a pending request.
    send(8'hC3, 1'b1, 1'b0, 6'd4);
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.tx", 32'(bus.tx_out), 32'd1);
    chk("midreset.busy", 32'(bus.busy), 32'd0);
    bus.p_data = 8'h5A;
    bus.par_en = 1'b0;
    bus.prescale = 6'd2;
    bus.data_valid = 1'b1;
    idle_check("in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    check_frame("after_reset", model_frame(8'h5A, 1'b0, 1'b0), 2, 20, 1'b0);
    idle_check("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Serial transmitter for the system's UART link. It takes a parallel byte from the system-side response path and sends it on the UART TX line. The frame format matches the command frames the RX side decodes: one start bit (0), data bits MSB first, optional parity bit, then one stop bit (1). It runs in the UART clock domain, drives the top-level UART TX output, and is paced by a per-bit prescale count.

## Interface
Parameters:
- DATA_WIDTH, 8, number of data bits per frame
- PRESCALE_W, 6, width of the PRESCALE input

Ports:
- CLK  input  1  UART-domain clock
- RST_N  input  1  asynchronous active-low reset
- P_DATA  input  DATA_WIDTH  byte to transmit
- DATA_VALID  input  1  request to send P_DATA; honoured only while BUSY=0
- PAR_EN  input  1  1 = parity bit included in the frame
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- PRESCALE  input  PRESCALE_W  CLK cycles per serial bit; 0 is treated as 1
- TX_OUT  output  1  serial line; idle high
- BUSY  output  1  high from the frame's start bit through its stop bit

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0.
  - If DATA_VALID=1 at a rising edge, latch P_DATA, PAR_EN, PAR_TYP and PRESCALE (0 is stored as 1), clear the bit counter, and go to START.
- START: TX_OUT=0 for PRESCALE cycles, then go to DATA with bit index DATA_WIDTH-1.
- DATA: TX_OUT = latched data[index] for PRESCALE cycles per bit. The index decrements until bit 0 is done. Then go to PARITY if the latched PAR_EN=1, otherwise to STOP.
- PARITY: TX_OUT = ^data when even, ~^data when odd, for PRESCALE cycles. Then go to STOP.
- STOP: TX_OUT=1 for PRESCALE cycles. Then go to IDLE.
- Frame length: (2 + DATA_WIDTH + PAR_EN) × PRESCALE cycles.
- Inputs are sampled only at acceptance. Changes to P_DATA, PAR_*, or PRESCALE during a frame have no effect on that frame.
- DATA_VALID while BUSY=1 is ignored. Requests are not queued, and no error is flagged.
- Counters:
  - Prescale counter is PRESCALE_W bits wide. It counts 0..PRESCALE-1 and wraps to 0 at each bit boundary.
  - Bit index is $clog2(DATA_WIDTH) bits wide.

## Timing
- Reset (asynchronous, RST_N=0): state=IDLE, TX_OUT=1, BUSY=0, counters=0, latched data=0. This takes effect immediately, including mid-frame. The line returns high within the reset assertion and no partial frame resumes.
- TX_OUT and BUSY are registered and glitch-free.
- Accept latency: DATA_VALID sampled high at edge n gives TX_OUT=0 and BUSY=1 from edge n (the same edge's register update). This is visible in cycle n+1.
- BUSY falls at the edge that ends the stop bit's last cycle. The earliest next acceptance is the following edge, so back-to-back frames have exactly one idle-high cycle between them.
- DATA_VALID held high continuously causes a frame to be resent every frame length + 1 cycles.
- Simultaneous reset release and DATA_VALID=1: the request is accepted at the first rising edge after RST_N goes high.

## Configuration
- Macro UART_TX_LSB_FIRST_EN.
  - Defined: data bits are sent LSB first. The bit index starts at 0 and increments to DATA_WIDTH-1.
  - Undefined (default): data bits are sent MSB first, as described above, matching the current RX decoder.
- Parity value, framing and timing are identical in both builds.

## Test plan
- Reset, then idle for 50 cycles -> TX_OUT=1 and BUSY=0 throughout. Assert RST_N low mid-frame -> TX_OUT=1 and BUSY=0 immediately.
- P_DATA=0x55, PAR_EN=1, PAR_TYP=0, PRESCALE=8 -> line shows 0,0,1,0,1,0,1,0,1,0 (parity even: 0),1, each held 8 cycles. BUSY is high for exactly 88 cycles.
- P_DATA=0xA0, PAR_EN=1, PAR_TYP=1, PRESCALE=16 -> data bits 1,0,1,0,0,0,0,0, then parity 1. Total 176 cycles.
- P_DATA=0x0F, PAR_EN=0, PRESCALE=0 -> 10-cycle frame (one cycle per bit), no parity bit.
- DATA_VALID held high with 0x33 then 0x44, PAR_EN=0, PRESCALE=8 -> 0x33 frame (80 cycles), 1 idle cycle, then the 0x44 frame. P_DATA changed mid-frame does not corrupt 0x33. A pulse while BUSY is dropped.
- Build with UART_TX_LSB_FIRST_EN, P_DATA=0x01, PAR_EN=1, PAR_TYP=0, PRESCALE=8 -> data bits 1,0,0,0,0,0,0,0, then parity 1.
